// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    // Default dividend/quotient and divisor/remainder widths.
    localparam int unsigned DivDw = 8;
    localparam int unsigned DivVw = 4;

    // Step counter must be able to hold the value DW.
    localparam int unsigned DivCw = $clog2(DivDw + 1);

    // Controller states, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StRun  = 2'd1;
    localparam state_t StDone = 2'd2;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
    parameter int unsigned VW = 4
) (
    input  logic [VW-1:0] i_pr,
    input  logic          i_bit,
    input  logic [VW-1:0] i_divisor,
    output logic [VW-1:0] o_pr,
    output logic          o_qbit
);

    // The incoming remainder is always below the divisor, so it fits VW bits;
    // the shifted value needs VW+1.
    logic [VW:0] w_shift;
    logic [VW:0] w_diff;
    logic        w_ge;

    // Trial subtraction and restore selection.
    always_comb begin
        w_shift = {i_pr, i_bit};
        w_ge    = (w_shift >= {1'b0, i_divisor});
        w_diff  = w_shift - {1'b0, i_divisor};
        o_qbit  = w_ge;
        o_pr    = w_ge ? w_diff[VW-1:0] : w_shift[VW-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// Start/busy/done handshake; divide-by-zero completes in a single cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned DW = DivDw,
    parameter int unsigned VW = DivVw
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_quotient,
    output logic [VW-1:0] o_remainder,
    output logic          o_div_by_zero
);

    localparam int unsigned CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LastStep = CW'(DW - 1);

    // State and working registers.
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_dvs;
    logic [VW-1:0] r_pr;
    logic [DW-1:0] r_quo;

    // Result registers, held until the next completion.
    logic [DW-1:0] r_quotient;
    logic [VW-1:0] r_remainder;
    logic          r_dbz;

    // Next-state values.
    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [DW-1:0] w_dvd_nxt;
    logic [VW-1:0] w_dvs_nxt;
    logic [VW-1:0] w_pr_nxt;
    logic [DW-1:0] w_quo_nxt;
    logic [DW-1:0] w_quotient_nxt;
    logic [VW-1:0] w_remainder_nxt;
    logic          w_dbz_nxt;

    // Step datapath outputs.
    logic [VW-1:0] w_step_pr;
    logic          w_step_qbit;

    div_step #(
        .VW (VW)
    ) u_step (
        .i_pr      (r_pr),
        .i_bit     (r_dvd[DW-1]),
        .i_divisor (r_dvs),
        .o_pr      (w_step_pr),
        .o_qbit    (w_step_qbit)
    );

    // Controller: accept, iterate DW times, then a single done cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_dvd_nxt       = r_dvd;
        w_dvs_nxt       = r_dvs;
        w_pr_nxt        = r_pr;
        w_quo_nxt       = r_quo;
        w_quotient_nxt  = r_quotient;
        w_remainder_nxt = r_remainder;
        w_dbz_nxt       = r_dbz;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (i_divisor == '0) begin
                        // Zero divisor skips the iteration entirely.
                        w_quotient_nxt  = '1;
                        w_remainder_nxt = '0;
                        w_dbz_nxt       = 1'b1;
                        w_state_nxt     = StDone;
                    end else begin
                        w_dvd_nxt   = i_dividend;
                        w_dvs_nxt   = i_divisor;
                        w_pr_nxt    = '0;
                        w_quo_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StRun;
                    end
                end
            end
            StRun: begin
                w_pr_nxt  = w_step_pr;
                w_dvd_nxt = {r_dvd[DW-2:0], 1'b0};
                w_quo_nxt = {r_quo[DW-2:0], w_step_qbit};
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LastStep) begin
                    w_quotient_nxt  = {r_quo[DW-2:0], w_step_qbit};
                    w_remainder_nxt = w_step_pr;
                    w_dbz_nxt       = 1'b0;
                    w_state_nxt     = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Register update; synchronous reset aborts any operation in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_pr        <= '0;
            r_quo       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dvd       <= w_dvd_nxt;
            r_dvs       <= w_dvs_nxt;
            r_pr        <= w_pr_nxt;
            r_quo       <= w_quo_nxt;
            r_quotient  <= w_quotient_nxt;
            r_remainder <= w_remainder_nxt;
            r_dbz       <= w_dbz_nxt;
        end
    end

    // Status decoded straight from state, so busy and done cannot overlap.
    always_comb begin
        o_busy        = (r_state == StRun);
        o_done        = (r_state == StDone);
        o_quotient    = r_quotient;
        o_remainder   = r_remainder;
        o_div_by_zero = r_dbz;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_assert = 0;
    int n_fail = 0;

    seq_divider dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept an operation and wait (bounded) for done. lat counts samples
    // after the accepting edge: 1 means done in the cycle right after it.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           output logic [7:0] q, output logic [3:0] r, output logic z,
                           output int lat, output int bcnt, output logic ov);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dividend = 8'hA5;
        divisor = 4'h3;
        lat = 1;
        bcnt = 0;
        ov = 1'b0;
        while (1) begin
            if (busy && done) ov = 1'b1;
            if (busy) bcnt++;
            if (done === 1'b1) break;
            if (lat >= 20) break;
            @(negedge clk);
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    logic       ov;
    int         lat;
    int         bcnt;
    int         ndone;
    logic       ok;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quo", 32'(quotient), 0);
        chk("rst_rem", 32'(remainder), 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        rst_n = 1'b1;

        // 200 / 7 with full timing checks.
        run_div(8'd200, 4'd7, q, r, z, lat, bcnt, ov);
        chk("200_7_lat", 32'(lat), 9);
        chk("200_7_busy", 32'(bcnt), 8);
        chk("200_7_overlap", 32'(ov), 0);
        chk("200_7_quo", 32'(q), 28);
        chk("200_7_rem", 32'(r), 4);
        chk("200_7_dbz", 32'(z), 0);
        @(negedge clk);
        chk("200_7_done_pulse", 32'(done), 0);
        chk("200_7_held_quo", 32'(quotient), 28);
        chk("200_7_held_rem", 32'(remainder), 4);

        run_div(8'd255, 4'd1, q, r, z, lat, bcnt, ov);
        chk("255_1_quo", 32'(q), 255);
        chk("255_1_rem", 32'(r), 0);
        chk("255_1_lat", 32'(lat), 9);

        // Divide by zero: one-cycle latency, busy never high.
        run_div(8'd100, 4'd0, q, r, z, lat, bcnt, ov);
        chk("dbz_quo", 32'(q), 255);
        chk("dbz_rem", 32'(r), 0);
        chk("dbz_flag", 32'(z), 1);
        chk("dbz_lat", 32'(lat), 1);
        chk("dbz_busy", 32'(bcnt), 0);

        run_div(8'd13, 4'd15, q, r, z, lat, bcnt, ov);
        chk("13_15_quo", 32'(q), 0);
        chk("13_15_rem", 32'(r), 13);
        chk("13_15_dbz_clr", 32'(z), 0);

        run_div(8'd0, 4'd5, q, r, z, lat, bcnt, ov);
        chk("0_5_quo", 32'(q), 0);
        chk("0_5_rem", 32'(r), 0);

        // Second start mid-RUN is ignored and does not queue.
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd200;
        divisor = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        dividend = 8'd9;
        divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ign_lat", 32'(lat), 9);
        chk("ign_quo", 32'(quotient), 28);
        chk("ign_rem", 32'(remainder), 4);
        @(negedge clk);
        @(negedge clk);
        chk("ign_no_queue_busy", 32'(busy), 0);
        chk("ign_no_queue_done", 32'(done), 0);

        // Reset at step 4 aborts with no done.
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd200;
        divisor = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_quo", 32'(quotient), 0);
        chk("abort_rem", 32'(remainder), 0);
        chk("abort_dbz", 32'(div_by_zero), 0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_no_activity", 32'(ndone), 0);
        run_div(8'd55, 4'd6, q, r, z, lat, bcnt, ov);
        chk("post_abort_quo", 32'(q), 9);
        chk("post_abort_rem", 32'(r), 1);
        chk("post_abort_lat", 32'(lat), 9);

        // Start and reset at the same edge: reset wins.
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        dividend = 8'd50;
        divisor = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_wins_done", 32'(done), 0);
        chk("rst_wins_busy", 32'(busy), 0);
        chk("rst_wins_dbz", 32'(div_by_zero), 0);

        // Exhaustive non-zero divisor sweep.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(8'(a), 4'(b), q, r, z, lat, bcnt, ov);
                ok = (lat == 9) && (z == 1'b0) && (int'(q) * b + int'(r) == a) &&
                     (int'(r) < b) && (int'(q) == a / b);
                n_assert++;
                assert (ok) else begin
                    n_fail++;
                    $error("FAIL sweep %0d/%0d: observed q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=9",
                           a, b, q, r, lat, a / b, a % b);
                end
            end
        end

        // Every 4x4 product divides back to its factor.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(8'(a * b), 4'(b), q, r, z, lat, bcnt, ov);
                n_assert++;
                assert (q === 8'(a) && r === 4'd0 && lat == 9) else begin
                    n_fail++;
                    $error("FAIL product %0d*%0d: observed q=%0d r=%0d expected q=%0d r=0",
                           a, b, q, r, a);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
